// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage: ID/EX pipeline register with write-back bypass and          |
// | load-use hazard bubble insertion.                       Revision: 1.0    |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [15:0]       id_imm16_i,
  input  logic [DATA_W-1:0] id_read_data1_i,
  input  logic [DATA_W-1:0] id_read_data2_i,
  input  logic [8:0]        id_ctrl_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_write_reg_i,
  input  logic [DATA_W-1:0] wb_write_data_i,
  input  logic              ext_stall_i,
  input  logic              flush_i,
  output logic              hazard_stall_o,
  output logic              ex_valid_o,
  output logic [REG_AW-1:0] ex_rs_o,
  output logic [REG_AW-1:0] ex_rt_o,
  output logic [REG_AW-1:0] ex_dest_o,
  output logic [DATA_W-1:0] ex_op_a_o,
  output logic [DATA_W-1:0] ex_op_b_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [8:0]        ex_ctrl_o
);

  localparam int c_MEMREAD_BIT = 7;
  localparam int c_REGDST_BIT  = 3;

  logic              valid_q, valid_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, imm_q, imm_d;
  logic [8:0]        ctrl_q, ctrl_d;

  logic [DATA_W-1:0] w_op_a, w_op_b;
  logic              w_hazard;

  // Register-file writes land too late to be read this cycle, so WB data is muxed in here.
  function automatic logic [DATA_W-1:0] bypass(
    input logic [REG_AW-1:0] idx,
    input logic [DATA_W-1:0] rf_data
  );
    if (idx == '0)
      return '0;
    else if (wb_reg_write_i && (wb_write_reg_i == idx))
      return wb_write_data_i;
    else
      return rf_data;
  endfunction

  assign w_op_a = bypass(id_rs_i, id_read_data1_i);
  assign w_op_b = bypass(id_rt_i, id_read_data2_i);

  assign w_hazard = id_valid_i && valid_q && ctrl_q[c_MEMREAD_BIT] && (rt_q != '0) &&
                    ((rt_q == id_rs_i) || (rt_q == id_rt_i));
  assign hazard_stall_o = w_hazard;

  always_comb begin
    valid_d = valid_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    dest_d  = dest_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (flush_i || (!ext_stall_i && w_hazard)) begin
      valid_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      dest_d  = '0;
      op_a_d  = '0;
      op_b_d  = '0;
      imm_d   = '0;
      ctrl_d  = '0;
    end else if (!ext_stall_i) begin
      valid_d = id_valid_i;
      rs_d    = id_rs_i;
      rt_d    = id_rt_i;
      dest_d  = id_ctrl_i[c_REGDST_BIT] ? id_rd_i : id_rt_i;
      op_a_d  = w_op_a;
      op_b_d  = w_op_b;
      imm_d   = {{(DATA_W-16){id_imm16_i[15]}}, id_imm16_i};
      ctrl_d  = id_valid_i ? id_ctrl_i : 9'd0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      dest_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      dest_q  <= dest_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid_o = valid_q;
  assign ex_rs_o    = rs_q;
  assign ex_rt_o    = rt_q;
  assign ex_dest_o  = dest_q;
  assign ex_op_a_o  = op_a_q;
  assign ex_op_b_o  = op_b_q;
  assign ex_imm_o   = imm_q;
  assign ex_ctrl_o  = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage: directed and randomized checks of id_ex_stage against a  |
// | behavioural reference model.                            Revision: 1.0    |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [15:0] id_imm16;
  logic [31:0] rd1, rd2;
  logic [8:0]  id_ctrl;
  logic        wb_we;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        ext_stall, flush;

  logic        hazard_stall, ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_dest;
  logic [31:0] ex_op_a, ex_op_b, ex_imm;
  logic [8:0]  ex_ctrl;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, dest;
    logic [31:0] a, b, imm;
    logic [8:0]  ctrl;
  } ex_t;

  ex_t  mdl;
  logic hz_seen;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clock_i         (clk),
    .reset_n_i       (reset_n),
    .id_valid_i      (id_valid),
    .id_rs_i         (id_rs),
    .id_rt_i         (id_rt),
    .id_rd_i         (id_rd),
    .id_imm16_i      (id_imm16),
    .id_read_data1_i (rd1),
    .id_read_data2_i (rd2),
    .id_ctrl_i       (id_ctrl),
    .wb_reg_write_i  (wb_we),
    .wb_write_reg_i  (wb_reg),
    .wb_write_data_i (wb_data),
    .ext_stall_i     (ext_stall),
    .flush_i         (flush),
    .hazard_stall_o  (hazard_stall),
    .ex_valid_o      (ex_valid),
    .ex_rs_o         (ex_rs),
    .ex_rt_o         (ex_rt),
    .ex_dest_o       (ex_dest),
    .ex_op_a_o       (ex_op_a),
    .ex_op_b_o       (ex_op_b),
    .ex_imm_o        (ex_imm),
    .ex_ctrl_o       (ex_ctrl)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: what the register file would effectively return this cycle.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return 32'd0;
    if (wb_we && wb_reg == idx) return wb_data;
    return rf;
  endfunction

  function automatic logic model_hazard(input ex_t cur);
    return id_valid && cur.valid && cur.ctrl[7] && cur.rt != 5'd0 &&
           (cur.rt == id_rs || cur.rt == id_rt);
  endfunction

  function automatic ex_t model_next(input ex_t cur);
    ex_t n;
    n = '0;
    if (!reset_n || flush) return n;
    if (ext_stall) return cur;
    if (model_hazard(cur)) return n;
    n.valid = id_valid;
    n.rs    = id_rs;
    n.rt    = id_rt;
    n.dest  = id_ctrl[3] ? id_rd : id_rt;
    n.a     = operand(id_rs, rd1);
    n.b     = operand(id_rt, rd2);
    n.imm   = 32'(signed'(id_imm16));
    n.ctrl  = id_valid ? id_ctrl : 9'd0;
    return n;
  endfunction

  task automatic compare_all();
    chk("ex_valid", 64'(ex_valid), 64'(mdl.valid));
    chk("ex_rs",    64'(ex_rs),    64'(mdl.rs));
    chk("ex_rt",    64'(ex_rt),    64'(mdl.rt));
    chk("ex_dest",  64'(ex_dest),  64'(mdl.dest));
    chk("ex_op_a",  64'(ex_op_a),  64'(mdl.a));
    chk("ex_op_b",  64'(ex_op_b),  64'(mdl.b));
    chk("ex_imm",   64'(ex_imm),   64'(mdl.imm));
    chk("ex_ctrl",  64'(ex_ctrl),  64'(mdl.ctrl));
  endtask

  // Inputs are already driven; check the combinational hazard, clock once, check EX.
  task automatic cycle();
    @(negedge clk);
    hz_seen = hazard_stall;
    chk("hazard_stall", 64'(hazard_stall), 64'(model_hazard(mdl)));
    @(posedge clk);
    mdl = model_next(mdl);
    #1;
    compare_all();
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                           input logic [15:0] imm, input logic [8:0] ctrl);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd;
    rd1 = d1; rd2 = d2; id_imm16 = imm; id_ctrl = ctrl;
  endtask

  initial begin
    // Reset with an aggressive instruction on the inputs
    reset_n = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
    set_instr(1'b1, 5'd1, 5'd2, 5'd3, 32'hAAAA, 32'hBBBB, 16'hFFFF, 9'h1FF);
    repeat (2) @(posedge clk);
    #1;
    mdl = '0;
    compare_all();

    // Plain capture with sign-extended immediate and RegDst
    reset_n = 1'b1;
    set_instr(1'b1, 5'd3, 5'd4, 5'd7, 32'h11, 32'h22, 16'h8001, 9'h108);
    cycle();
    chk("t2_op_a", 64'(ex_op_a), 64'h11);
    chk("t2_op_b", 64'(ex_op_b), 64'h22);
    chk("t2_imm",  64'(ex_imm),  64'hFFFF8001);
    chk("t2_dest", 64'(ex_dest), 64'd7);

    // Write-back bypass on rs, then register 0 is never bypassed
    wb_we = 1'b1; wb_reg = 5'd3; wb_data = 32'hDEAD;
    cycle();
    chk("t3_op_a_bypass", 64'(ex_op_a), 64'hDEAD);
    chk("t3_op_b_kept",   64'(ex_op_b), 64'h22);
    wb_reg = 5'd0; id_rs = 5'd0; rd1 = 32'h1234;
    cycle();
    chk("t3_op_a_zero", 64'(ex_op_a), 64'd0);

    // Load-use hazard: lw with rt=5, then a consumer of r5
    wb_we = 1'b0;
    set_instr(1'b1, 5'd1, 5'd5, 5'd0, 32'h1, 32'h2, 16'h0004, 9'h1B0);
    cycle();
    set_instr(1'b1, 5'd5, 5'd2, 5'd9, 32'h55, 32'h66, 16'h0010, 9'h108);
    cycle();
    chk("t4_hazard_seen", 64'(hz_seen), 64'd1);
    chk("t4_bubble_valid", 64'(ex_valid), 64'd0);
    chk("t4_bubble_ctrl",  64'(ex_ctrl),  64'd0);
    cycle();
    chk("t4_hazard_clear", 64'(hz_seen), 64'd0);
    chk("t4_load_valid", 64'(ex_valid), 64'd1);
    chk("t4_load_op_a",  64'(ex_op_a),  64'h55);
    chk("t4_load_dest",  64'(ex_dest),  64'd9);
    chk("t4_load_ctrl",  64'(ex_ctrl),  64'h108);

    // External stall holds EX while ID changes; flush beats stall
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(1'b1, 5'(10 + i), 5'(11 + i), 5'd12, 32'($urandom), 32'($urandom),
                16'($urandom), 9'h1FF);
      cycle();
      chk("t5_hold_op_a", 64'(ex_op_a), 64'h55);
      chk("t5_hold_ctrl", 64'(ex_ctrl), 64'h108);
    end
    flush = 1'b1;
    cycle();
    chk("t5_flush_valid", 64'(ex_valid), 64'd0);
    chk("t5_flush_ctrl",  64'(ex_ctrl),  64'd0);

    // Reset while stalled, then resume
    flush = 1'b0; ext_stall = 1'b0;
    set_instr(1'b1, 5'd6, 5'd7, 5'd8, 32'h66, 32'h77, 16'h0123, 9'h110);
    cycle();
    ext_stall = 1'b1; reset_n = 1'b0;
    cycle();
    chk("t6_rst_valid", 64'(ex_valid), 64'd0);
    chk("t6_rst_op_a",  64'(ex_op_a),  64'd0);
    chk("t6_rst_ctrl",  64'(ex_ctrl),  64'd0);
    ext_stall = 1'b0; reset_n = 1'b1;
    cycle();
    chk("t6_resume_op_b", 64'(ex_op_b), 64'h77);
    chk("t6_resume_imm",  64'(ex_imm),  64'h123);

    // Random traffic on a small register set to provoke hazards and bypasses
    for (int n = 0; n < 400; n++) begin
      reset_n   = ($urandom_range(0, 63) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      ext_stall = ($urandom_range(0, 5) == 0);
      wb_we     = $urandom_range(0, 1) == 1;
      wb_reg    = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      set_instr($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 31)), $urandom, $urandom, 16'($urandom),
                9'($urandom));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
